// File: rtl/mem_controller.sv
// Arbitrates a fetch client and a data client onto a synchronous RAM, one
// transaction at a time; every output comes straight from a flop.
module mem_controller #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_req,
   input  logic [A_WIDTH-1:0] if_addr,
   output logic               if_ack,
   output logic [D_WIDTH-1:0] if_data,
   input  logic               dm_req,
   input  logic               dm_we,
   input  logic [A_WIDTH-1:0] dm_addr,
   input  logic [D_WIDTH-1:0] dm_wdata,
   output logic               dm_ack,
   output logic [D_WIDTH-1:0] dm_rdata,
   output logic [A_WIDTH-1:0] address_write,
   output logic [D_WIDTH-1:0] data_write,
   output logic               write_enable,
   output logic [A_WIDTH-1:0] address_read,
   input  logic [D_WIDTH-1:0] data_read
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

   state_t             state_q, state_d;
   logic               grant_dm_q, grant_dm_d;
   logic               is_wr_q, is_wr_d;
   logic [1:0]         streak_q, streak_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic [D_WIDTH-1:0] wdata_q, wdata_d;
   logic               we_q, we_d;
   logic               if_ack_q, if_ack_d;
   logic               dm_ack_q, dm_ack_d;
   logic [D_WIDTH-1:0] if_data_q, if_data_d;
   logic [D_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic               pick_dm;

   // The data port normally wins; after two consecutive contested data grants the fetch port gets a turn.
   assign pick_dm = dm_req && !(if_req && (streak_q == 2'd2));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_dm_q <= 1'b0;
         is_wr_q    <= 1'b0;
         streak_q   <= 2'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_data_q  <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_dm_q <= grant_dm_d;
         is_wr_q    <= is_wr_d;
         streak_q   <= streak_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         if_data_q  <= if_data_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_dm_d = grant_dm_q;
      is_wr_d    = is_wr_q;
      streak_d   = streak_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      if_data_d  = if_data_q;
      dm_rdata_d = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               state_d    = ISSUE;
               grant_dm_d = pick_dm;
               if (pick_dm) begin
                  addr_d  = dm_addr;
                  is_wr_d = dm_we;
                  we_d    = dm_we;
                  if (dm_we) wdata_d = dm_wdata;
                  if (!if_req)                streak_d = 2'd0;
                  else if (streak_q != 2'd2)  streak_d = streak_q + 2'd1;
               end else begin
                  addr_d   = if_addr;
                  is_wr_d  = 1'b0;
                  streak_d = 2'd0;
               end
            end
         end
         ISSUE: begin
            if (is_wr_q) begin
               state_d  = ACK;
               dm_ack_d = 1'b1;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            state_d = ACK;
            if (grant_dm_q) begin
               dm_rdata_d = data_read;
               dm_ack_d   = 1'b1;
            end else begin
               if_data_d = data_read;
               if_ack_d  = 1'b1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign address_write = addr_q;
   assign address_read  = addr_q;
   assign data_write    = wdata_q;
   assign write_enable  = we_q;
   assign if_ack        = if_ack_q;
   assign dm_ack        = dm_ack_q;
   assign if_data       = if_data_q;
   assign dm_rdata      = dm_rdata_q;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: synchronous RAM, directed scenarios with literal
// expectations, then randomized clients checked every cycle against a transaction model.
module tb_mem_controller;
   localparam int DW = 8;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          if_ack, dm_ack, write_enable;
   logic [DW-1:0] if_data, dm_rdata, data_write, data_read;
   logic [AW-1:0] address_write, address_read;

   int n_chk = 0;
   int n_err = 0;

   mem_controller #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .address_write(address_write), .data_write(data_write),
      .write_enable(write_enable), .address_read(address_read),
      .data_read(data_read)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int i);
      return 8'(i * 7 + 3);
   endfunction

   // Synchronous RAM: write on the edge, read data one cycle after the address.
   logic [DW-1:0] ram [32];
   logic          ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
         ram_ready <= 1'b1;
      end else if (write_enable) begin
         ram[address_write] <= data_write;
      end
      data_read <= ram[address_read];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: grant decision, fixed latencies, reference memory.
   int            cyc = 0;
   int            m_free_at, m_if_ack_at, m_dm_ack_at, m_we_at, m_issue_at, m_commit_at;
   int            m_streak;
   bit            m_dm_is_rd;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_if_data, m_dm_rdata, m_if_pend, m_dm_pend;
   logic [DW-1:0] ref_mem [32];

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
      m_free_at = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            m_if_ack_at = -100; m_dm_ack_at = -100; m_we_at = -100;
            m_issue_at = -100; m_commit_at = -100;
            m_streak = 0; m_if_data = '0; m_dm_rdata = '0; m_dm_is_rd = 1'b0;
            m_addr = '0; m_wdata = '0;
            m_free_at = cyc + 1;
         end else begin
            if (cyc == m_commit_at) ref_mem[m_addr] = m_wdata;
            if (cyc == m_if_ack_at) m_if_data = m_if_pend;
            if (cyc == m_dm_ack_at && m_dm_is_rd) m_dm_rdata = m_dm_pend;
            if (cyc >= m_free_at && (if_req || dm_req)) begin
               m_issue_at = cyc;
               if (dm_req && !(if_req && m_streak == 2)) begin
                  m_streak = if_req ? ((m_streak == 2) ? 2 : m_streak + 1) : 0;
                  m_addr = dm_addr;
                  if (dm_we) begin
                     m_dm_is_rd = 1'b0;
                     m_wdata = dm_wdata;
                     m_we_at = cyc;
                     m_commit_at = cyc + 1;
                     m_dm_ack_at = cyc + 1;
                     m_free_at = cyc + 3;
                  end else begin
                     m_dm_is_rd = 1'b1;
                     m_dm_pend = ref_mem[dm_addr];
                     m_dm_ack_at = cyc + 2;
                     m_free_at = cyc + 4;
                  end
               end else begin
                  m_streak = 0;
                  m_addr = if_addr;
                  m_if_pend = ref_mem[if_addr];
                  m_if_ack_at = cyc + 2;
                  m_free_at = cyc + 4;
               end
            end
         end
      end
   end

   // Per-cycle comparison on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("rst_ctl", {if_ack, dm_ack, write_enable}, 0);
            chk("rst_addr", {address_write, address_read}, 0);
            chk("rst_data", {data_write, if_data, dm_rdata}, 0);
         end else begin
            chk("if_ack", if_ack, cyc == m_if_ack_at);
            chk("dm_ack", dm_ack, cyc == m_dm_ack_at);
            chk("write_enable", write_enable, cyc == m_we_at);
            chk("ack_overlap", if_ack & dm_ack, 0);
            chk("if_data", if_data, m_if_data);
            chk("dm_rdata", dm_rdata, m_dm_rdata);
            if (cyc == m_issue_at) begin
               chk("issue_addr_w", address_write, m_addr);
               chk("issue_addr_r", address_read, m_addr);
            end
            if (cyc == m_we_at) chk("issue_wdata", data_write, m_wdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected to finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   int            we_cnt;
   logic [AW-1:0] we_addr;
   logic [DW-1:0] we_data;

   task automatic txn(input bit is_dm, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rdata);
      if (is_dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      lat = -1; we_cnt = 0; rdata = '0;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
         step();
         if (write_enable) begin
            we_cnt++; we_addr = address_write; we_data = data_write;
         end
         if (is_dm ? dm_ack : if_ack) begin
            lat = i;
            rdata = is_dm ? dm_rdata : if_data;
         end
      end
      if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
      if (lat < 0) chk("txn_timeout", 0, 1);
      step();
   endtask

   int            lat, first_dm, ovl, dm_cnt, dacks_before;
   bit            if_done, ack_seen;
   logic [DW-1:0] rd, saved, c_dm, c_if;

   initial begin
      reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (3) step();
      chk("reset_outs", {if_ack, dm_ack, write_enable, if_data, dm_rdata}, 0);
      reset = 1'b0;
      step();

      // Write 0xC5 to 0x1B
      txn(1'b1, 1'b1, 5'h1B, 8'hC5, lat, rd);
      chk("wr_lat", lat, 2);
      chk("wr_we_cnt", we_cnt, 1);
      chk("wr_addr", we_addr, 5'h1B);
      chk("wr_data", we_data, 8'hC5);

      // Fetch of the freshly written word
      saved = dm_rdata;
      txn(1'b0, 1'b0, 5'h1B, 8'h00, lat, rd);
      chk("rd_lat", lat, 3);
      chk("rd_data", rd, 8'hC5);
      chk("rd_dm_hold", dm_rdata, saved);

      // Simultaneous requests: data port first
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'h02;
      if_req = 1'b1; if_addr = 5'h01;
      first_dm = -1; ovl = 0; c_dm = '0; c_if = '0;
      for (int i = 0; i < 30 && (dm_req || if_req); i++) begin
         step();
         if (dm_ack && if_ack) ovl++;
         if (dm_ack) begin
            if (first_dm < 0) first_dm = 1;
            c_dm = dm_rdata; dm_req = 1'b0;
         end
         if (if_ack) begin
            if (first_dm < 0) first_dm = 0;
            c_if = if_data; if_req = 1'b0;
         end
      end
      chk("both_done", {dm_req, if_req}, 0);
      chk("both_order_dm_first", first_dm, 1);
      chk("both_dm_data", c_dm, 8'h11);
      chk("both_if_data", c_if, 8'h0A);
      chk("both_overlap", ovl, 0);
      step();

      // Data port re-raised back to back while fetch waits
      if_req = 1'b1; if_addr = 5'h05;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'h06;
      if_done = 1'b0; dm_cnt = 0; dacks_before = -1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (dm_ack) begin
            dm_cnt++; dm_req = 1'b0;
         end else if (!dm_req && !if_done) begin
            dm_req = 1'b1;
         end
         if (if_ack) begin
            if_done = 1'b1; dacks_before = dm_cnt; if_req = 1'b0;
         end
         if (if_done && !dm_req) break;
      end
      chk("streak_dm_grants_before_fetch", dacks_before, 2);
      dm_req = 1'b0; if_req = 1'b0;
      step();

      // Address/data changed during ISSUE of a write
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'h1B; dm_wdata = 8'hC5;
      step();
      chk("midchg_we_issue", write_enable, 1);
      dm_addr = 5'h03; dm_wdata = 8'h99;
      #1;
      chk("midchg_addr_hold", address_write, 5'h1B);
      chk("midchg_data_hold", data_write, 8'hC5);
      lat = -1;
      for (int i = 0; i < 10 && lat < 0; i++) begin
         step();
         if (dm_ack) lat = i;
      end
      dm_req = 1'b0;
      chk("midchg_ack", lat, 0);
      step();
      txn(1'b1, 1'b0, 5'h03, 8'h00, lat, rd);
      chk("midchg_mem03", rd, 8'h18);

      // Reset during ISSUE of a write aborts it
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'h1B; dm_wdata = 8'h7E;
      step();
      chk("abort_we_issue", write_enable, 1);
      reset = 1'b1;
      #1;
      chk("abort_we_drop", write_enable, 0);
      dm_req = 1'b0; ack_seen = 1'b0;
      repeat (2) begin step(); ack_seen |= dm_ack; end
      reset = 1'b0;
      repeat (3) begin step(); ack_seen |= dm_ack; end
      chk("abort_no_ack", ack_seen, 0);
      txn(1'b0, 1'b0, 5'h1B, 8'h00, lat, rd);
      chk("abort_rd_lat", lat, 3);
      chk("abort_rd_data", rd, 8'hC5);

      // Randomized traffic; addresses and data churn every cycle, req obeys the handshake
      for (int i = 0; i < 400; i++) begin
         step();
         if (if_req && if_ack) if_req = 1'b0;
         else if (!if_req && $urandom_range(0, 3) == 0) if_req = 1'b1;
         if (dm_req && dm_ack) dm_req = 1'b0;
         else if (!dm_req && $urandom_range(0, 2) == 0) dm_req = 1'b1;
         if_addr = AW'($urandom);
         dm_addr = AW'($urandom);
         dm_we = 1'($urandom);
         dm_wdata = DW'($urandom);
      end
      for (int i = 0; i < 40 && (if_req || dm_req); i++) begin
         step();
         if (if_req && if_ack) if_req = 1'b0;
         if (dm_req && dm_ack) dm_req = 1'b0;
      end
      chk("drain", {if_req, dm_req}, 0);
      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_controller.md
MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, data word width.
REQ-002 The block SHALL have parameter A_WIDTH, default 5, address width; the memory depth is 2^A_WIDTH.
REQ-003 The block SHALL have port clk, input, 1, the single clock; it also drives the RAM clk_write and clk_read at top level.
REQ-004 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have port if_req, input, 1, fetch read request, held as a level until if_ack.
REQ-006 The block SHALL have port if_addr, input, A_WIDTH, fetch address.
REQ-007 The block SHALL have ports if_ack (output, 1, one-cycle completion pulse) and if_data (output, D_WIDTH, fetched word).
REQ-008 The block SHALL have ports dm_req (input, 1), dm_we (input, 1, 1=write), dm_addr (input, A_WIDTH) and dm_wdata (input, D_WIDTH).
REQ-009 The block SHALL have ports dm_ack (output, 1, one-cycle pulse) and dm_rdata (output, D_WIDTH, load data).
REQ-010 The block SHALL have RAM-side outputs address_write (A_WIDTH), data_write (D_WIDTH), write_enable (1) and address_read (A_WIDTH).
REQ-011 The block SHALL have RAM-side input data_read (D_WIDTH).

Function
REQ-012 The RAM SHALL be treated as synchronous: a write commits on the clk edge where write_enable=1, and data_read is valid in the cycle after address_read is sampled.
REQ-013 The FSM SHALL have states IDLE, ISSUE, CAPTURE and ACK, and all outputs SHALL be registered.
REQ-014 IDLE SHALL sample the requests: if any is pending, it grants one requester, latches its address (and we/wdata for the data port) into RAM-side registers, and goes to ISSUE; otherwise it stays in IDLE.
REQ-015 In ISSUE, address_read and address_write SHALL equal the latched address, and write_enable=1 only for a data-port write.
REQ-016 ISSUE SHALL go to ACK for a write and to CAPTURE for a read.
REQ-017 CAPTURE SHALL register data_read into if_data or dm_rdata per the grant, then go to ACK.
REQ-018 ACK SHALL pulse exactly the granted client's ack for one cycle, accept no new grant, and return to IDLE.
REQ-019 Write latency SHALL be: dm_ack high in the 2nd cycle after the grant edge.
REQ-020 Read latency SHALL be: the ack is high in the 3rd cycle after the grant edge, with data valid in the same cycle.
REQ-021 if_data and dm_rdata SHALL hold their last value until that port's next read capture.
REQ-022 Clients SHALL drop req on the edge where they sample ack=1; a req still high in IDLE after ACK SHALL be treated as a new request.
REQ-023 Request inputs, addresses and wdata SHALL be ignored outside IDLE; changes mid-transaction SHALL not affect the transaction in flight.
REQ-024 Arbitration when both requests are pending SHALL be: the data port wins, unless dm_streak==2, in which case the fetch port wins.
REQ-025 dm_streak (2-bit) SHALL increment, saturating at 2, on a data-port grant made while if_req=1.
REQ-026 dm_streak SHALL clear on any fetch grant and on a data-port grant made while if_req=0.
REQ-027 write_enable SHALL never be high outside ISSUE, and SHALL be high for at most one cycle per write.
REQ-028 At most one transaction SHALL be in flight, and if_ack and dm_ack SHALL never be high together.

Reset
REQ-029 While reset is high, state SHALL be IDLE and dm_streak=0.
REQ-030 While reset is high, if_ack, dm_ack, write_enable, address_write, address_read, data_write, if_data and dm_rdata SHALL all be 0.
REQ-031 Reset asserted mid-transaction SHALL drop write_enable immediately, abort the transaction, and issue no ack for it.

Verification
REQ-032 Bench: dm write of 0xC5 to 0x1B -> write_enable high exactly 1 cycle with address_write=0x1B and data_write=0xC5; dm_ack 2 cycles after the grant.
REQ-033 Bench: fetch read of 0x1B after that write -> if_ack 3 cycles after the grant with if_data=0xC5; dm_rdata unchanged.
REQ-034 Bench: if_req and dm_req rise in the same cycle (dm read 0x02, fetch 0x01) -> dm_ack with dm_rdata=mem[0x02] first, then if_ack with mem[0x01]; acks never overlap.
REQ-035 Bench: dm_req re-raised back-to-back with if_req held high -> the fetch is granted after exactly 2 data grants.
REQ-036 Bench: dm_addr changed 0x1B->0x03 during ISSUE of a write -> address_write stays 0x1B and mem[0x03] is unchanged.
REQ-037 Bench: reset pulsed during ISSUE of a write of 0x7E to 0x1B -> write_enable drops immediately, no dm_ack, and a later read of 0x1B returns 0xC5.
